map_wr_arbiter: RTL and testbench

- Shares the single map RAM write port (port B) between several tile-update requesters: pacman mover, ghost AI, and pill/restore logic.
- Each granted request runs one read-modify-write of a 160-bit map row. The row is read, one 4-bit tile nibble is replaced, and the row is written back.
- Sits between the sprite controllers and map_RAM port B. The display path on port A is unaffected.

---
 rtl/map_pkg.sv | 24 ++
 rtl/map_wr_arbiter_rr_arbiter.sv | 32 +++
 rtl/map_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_map_wr_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// map_pkg: shared map geometry, tile codes and nibble addressing helper.
package map_pkg;

    localparam int MAP_ROWS = 30;
    localparam int MAP_COLS = 40;
    localparam int TILE_W   = 4;
    localparam int ROW_W    = 160;

    typedef enum logic [3:0] {
        EMPTY  = 4'h0,
        WALL   = 4'h1,
        PILL   = 4'h2,
        PACMAN = 4'h3,
        GHOST  = 4'h4,
        POWER  = 4'h5,
        DOOR   = 4'h6
    } tile_t;

    // Column 0 sits in the top nibble of the row, column 39 in the bottom one.
    function automatic int nibble_lsb(input logic [5:0] col);
        return ROW_W - 1 - TILE_W * int'(col) - (TILE_W - 1);
    endfunction

endpackage

// File: rtl/map_wr_arbiter_rr_arbiter.sv
// rr_arbiter: pointer-based round-robin pick; first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic [NREQ-1:0]         onehot
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] j;

    // Scan from the pointer with wrap-around and stop at the first active request.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = IW'((32'(ptr) + k) % 32'(NREQ));
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_wr_arbiter.sv
// map_wr_arbiter: shares map RAM port B among tile-update requesters, one
// read-modify-write of a 160-bit row per grant.
// Optional: define MAP_WR_ARB_PREV_TILE_EN to report the overwritten tile on prev_tile.
module map_wr_arbiter
    import map_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int RD_LAT   = 1,
    parameter int MAP_COLS = map_pkg::MAP_COLS
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*5-1:0]       row_in,
    input  logic [NREQ*6-1:0]       col_in,
    input  logic [NREQ*4-1:0]       tile_in,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic [4:0]              wraddr,
    output logic                    wren,
    output logic [ROW_W-1:0]        wrdata,
    input  logic [ROW_W-1:0]        redata,
    output logic [TILE_W-1:0]       prev_tile
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]        state;
    logic [3:0]        rd_cnt;
    logic [IW-1:0]     ptr;
    logic [4:0]        row_q;
    logic [5:0]        col_q;
    logic [TILE_W-1:0] tile_q;
    logic [NREQ-1:0]   onehot_q;

    logic              arb_any;
    logic [IW-1:0]     arb_idx;
    logic [NREQ-1:0]   arb_onehot;

    logic [4:0]        row_arr  [NREQ];
    logic [5:0]        col_arr  [NREQ];
    logic [TILE_W-1:0] tile_arr [NREQ];

    logic              col_bad;
    int                lsb;
    logic [ROW_W-1:0]  new_row;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign row_arr[g]  = row_in[5*g +: 5];
        assign col_arr[g]  = col_in[6*g +: 6];
        assign tile_arr[g] = tile_in[4*g +: 4];
    end

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req    (req),
        .ptr    (ptr),
        .any    (arb_any),
        .idx    (arb_idx),
        .onehot (arb_onehot)
    );

    assign busy = (state != S_IDLE);

    // Splice the latched tile into the row just read back.
    always_comb begin
        col_bad = (32'(col_q) >= MAP_COLS);
        lsb     = nibble_lsb(col_q);
        new_row = (redata & ~(ROW_W'(4'hF) << lsb)) | (ROW_W'(tile_q) << lsb);
    end

`ifdef MAP_WR_ARB_PREV_TILE_EN
    logic [TILE_W-1:0] prev_q;
    assign prev_tile = prev_q;
`else
    assign prev_tile = 4'h0;
`endif

    // Grant / read / write / acknowledge sequencer; all outputs registered.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            ptr       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            tile_q    <= '0;
            onehot_q  <= '0;
            grant_idx <= '0;
            wraddr    <= '0;
            wren      <= 1'b0;
            wrdata    <= '0;
            done      <= '0;
            err       <= 1'b0;
`ifdef MAP_WR_ARB_PREV_TILE_EN
            prev_q    <= '0;
`endif
        end else begin
            wren <= 1'b0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        row_q     <= row_arr[arb_idx];
                        col_q     <= col_arr[arb_idx];
                        tile_q    <= tile_arr[arb_idx];
                        onehot_q  <= arb_onehot;
                        grant_idx <= arb_idx;
                        wraddr    <= row_arr[arb_idx];
                        rd_cnt    <= '0;
                        state     <= S_RD;
                    end
                end
                S_RD: begin
                    if (col_bad) begin
                        done  <= onehot_q;
                        err   <= 1'b1;
                        state <= S_ACK;
                    end else if (32'(rd_cnt) == RD_LAT) begin
                        // wrdata doubles as the row buffer: capture and modify in one step
                        wrdata <= new_row;
                        wren   <= 1'b1;
                        state  <= S_WR;
`ifdef MAP_WR_ARB_PREV_TILE_EN
                        prev_q <= 4'(redata >> lsb);
`endif
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                S_WR: begin
                    done  <= onehot_q;
                    state <= S_ACK;
                end
                default: begin
                    ptr   <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_wr_arbiter.sv
// tb_map_wr_arbiter: directed plan cases plus randomized traffic against a
// transaction-level model (round-robin order, row image, latency).
module tb_map_wr_arbiter;
    import map_pkg::*;

    localparam int NREQ = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   req;
    logic [14:0]  row_in;
    logic [17:0]  col_in;
    logic [11:0]  tile_in;
    logic [2:0]   done;
    logic         err;
    logic         busy;
    logic [1:0]   grant_idx;
    logic [4:0]   wraddr;
    logic         wren;
    logic [159:0] wrdata;
    logic [159:0] redata = '0;
    logic [3:0]   prev_tile;

    always #5 clk = ~clk;

    map_wr_arbiter #(.NREQ(3), .RD_LAT(1), .MAP_COLS(40)) dut (
        .CLOCK_50  (clk),
        .reset     (rst),
        .req       (req),
        .row_in    (row_in),
        .col_in    (col_in),
        .tile_in   (tile_in),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .grant_idx (grant_idx),
        .wraddr    (wraddr),
        .wren      (wren),
        .wrdata    (wrdata),
        .redata    (redata),
        .prev_tile (prev_tile)
    );

    // Map RAM port B: one-cycle read latency, plus a preload port for the bench.
    logic [159:0] ram [32];
    logic         ld_en = 1'b0;
    logic [4:0]   ld_addr = '0;
    logic [159:0] ld_data = '0;
    always @(posedge clk) begin
        redata <= ram[wraddr];
        if (wren) ram[wraddr] <= wrdata;
        if (ld_en) ram[ld_addr] <= ld_data;
    end

    // Reference state
    logic [159:0] mdl [32];
    bit           act [3];
    logic [4:0]   row_f [3];
    logic [5:0]   col_f [3];
    logic [3:0]   tile_f [3];
    int           ptr_m;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            req[k]           = act[k];
            row_in[5*k +: 5] = row_f[k];
            col_in[6*k +: 6] = col_f[k];
            tile_in[4*k +: 4] = tile_f[k];
        end
    endtask

    task automatic new_req(input int k, input bit allow_bad);
        row_f[k]  = 5'($urandom_range(0, 31));
        col_f[k]  = (allow_bad && $urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 63))
                                                               : 6'($urandom_range(0, 39));
        tile_f[k] = 4'($urandom_range(0, 15));
        act[k]    = 1'b1;
    endtask

    // Runs one grant to completion from a negedge; from_idle means the next
    // posedge is the sampling edge (otherwise the DUT is currently in ACK).
    task automatic do_txn(input bit from_idle, input bit drop, output int gidx);
        int           idx;
        bit           perr;
        int           lat;
        int           p;
        int           n;
        int           wcnt;
        bit           got;
        logic [159:0] exp_row;
        logic [3:0]   old_nib;
        logic [4:0]   waddr_s;
        logic [159:0] wdata_s;
        idx = 0;
        got = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (act[(ptr_m + k) % NREQ]) idx = (ptr_m + k) % NREQ;
        perr    = (int'(col_f[idx]) >= 40);
        exp_row = mdl[row_f[idx]];
        old_nib = '0;
        if (!perr) begin
            p = 159 - 4 * int'(col_f[idx]);
            old_nib = exp_row[p -: 4];
            exp_row[p -: 4] = tile_f[idx];
        end
        lat     = (perr ? 2 : 4) + (from_idle ? 0 : 1);
        n       = 0;
        wcnt    = 0;
        waddr_s = '0;
        wdata_s = '0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (wren) begin
                wcnt++;
                waddr_s = wraddr;
                wdata_s = wrdata;
            end
            if (drop && n == 2) begin
                act[idx] = 1'b0;
                drive();
            end
            if (done != 3'b000) got = 1'b1;
        end
        check_val("done_seen", got, 1);
        check_val("latency", n, lat);
        check_val("done_vec", done, 160'(3'b001 << idx));
        check_val("err", err, perr);
        check_val("grant_idx", grant_idx, idx);
        check_val("busy_ack", busy, 1);
        check_val("wren_count", wcnt, perr ? 0 : 1);
        if (!perr) begin
            check_val("wraddr", waddr_s, row_f[idx]);
            check_val("wrdata", wdata_s, exp_row);
            mdl[row_f[idx]] = exp_row;
`ifdef MAP_WR_ARB_PREV_TILE_EN
            check_val("prev_tile", prev_tile, old_nib);
`endif
        end
`ifndef MAP_WR_ARB_PREV_TILE_EN
        check_val("prev_tile_off", prev_tile, 0);
`endif
        ptr_m    = (idx + 1) % NREQ;
        act[idx] = 1'b0;
        gidx     = idx;
    endtask

    initial begin
        int           g;
        int           n;
        logic [159:0] d;

        rst = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 3; k++) begin
            act[k] = 1'b0; row_f[k] = '0; col_f[k] = '0; tile_f[k] = '0;
        end
        drive();

        // Preload RAM and the model with the same contents.
        @(negedge clk);
        ld_en = 1'b1;
        for (int r = 0; r < 32; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (r == 5)  d = '1;
            if (r == 29) d = '0;
            if (r == 7)  d[159-40 -: 4] = 4'h2;
            mdl[r]  = d;
            ld_addr = 5'(r);
            ld_data = d;
            @(negedge clk);
        end
        ld_en = 1'b0;

        // Reset state
        check_val("rst_wren", wren, 0);
        check_val("rst_wraddr", wraddr, 0);
        check_val("rst_wrdata", wrdata, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant_idx, 0);
        check_val("rst_prev", prev_tile, 0);

        rst = 1'b0;
        @(negedge clk);

        // Single request, row 5 all ones, col 0
        act[0] = 1'b1; row_f[0] = 5'd5; col_f[0] = 6'd0; tile_f[0] = PACMAN;
        drive();
        do_txn(1'b1, 1'b0, g);
        check_val("first_row5", mdl[5], {4'h3, {156{1'b1}}});
        drive();
        @(negedge clk);

        // Last column
        act[1] = 1'b1; row_f[1] = 5'd29; col_f[1] = 6'd39; tile_f[1] = PILL;
        drive();
        do_txn(1'b1, 1'b0, g);
        check_val("last_col_row29", mdl[29], 160'h2);
        drive();
        @(negedge clk);

        // Invalid column
        act[2] = 1'b1; row_f[2] = 5'd3; col_f[2] = 6'd40; tile_f[2] = WALL;
        drive();
        do_txn(1'b1, 1'b0, g);
        drive();
        @(negedge clk);

        // Overwrite a pill at row 7 col 10
        act[0] = 1'b1; row_f[0] = 5'd7; col_f[0] = 6'd10; tile_f[0] = EMPTY;
        drive();
        do_txn(1'b1, 1'b0, g);
        drive();
        @(negedge clk);

        // Abort during WR
        new_req(1, 1'b0);
        drive();
        n = 0;
        while (!wren && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_wr_seen", wren, 1);
        rst = 1'b1;
        #1;
        check_val("abort_wren", wren, 0);
        check_val("abort_done", done, 0);
        check_val("abort_busy", busy, 0);
        ptr_m = 0;
        @(negedge clk);
        check_val("abort_done_hold", done, 0);
        new_req(0, 1'b0);
        new_req(2, 1'b0);
        drive();
        rst = 1'b0;
        do_txn(1'b1, 1'b0, g);
        check_val("abort_next_grant", g, 0);

        // Contention between requesters 0 and 2
        act[1] = 1'b0;
        new_req(0, 1'b0);
        drive();
        for (int t = 0; t < 4; t++) begin
            do_txn(1'b0, 1'b0, g);
            new_req(g, 1'b0);
            drive();
        end

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            do_txn(1'b0, ($urandom_range(0, 5) == 0), g);
            if ($urandom_range(0, 3) != 0) new_req(g, 1'b1);
            for (int k = 0; k < 3; k++)
                if (!act[k] && $urandom_range(0, 1) == 1) new_req(k, 1'b1);
            if (!act[0] && !act[1] && !act[2]) new_req(int'($urandom_range(0, 2)), 1'b1);
            drive();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
